// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST wrapper.
// Holds the LFSR/MISR tap tables and the sequencer states.
package gate_bist_pkg;

  localparam int CNT_W = 21;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Maximal-length Fibonacci taps, bit t-1 set for tap t
  function automatic logic [31:0] tap(input int n);
    case (n)
      8:       tap = 32'h0000_00B8;
      9:       tap = 32'h0000_0110;
      10:      tap = 32'h0000_0240;
      11:      tap = 32'h0000_0500;
      12:      tap = 32'h0000_0829;
      13:      tap = 32'h0000_100D;
      14:      tap = 32'h0000_2015;
      15:      tap = 32'h0000_6000;
      16:      tap = 32'h0000_D008;
      17:      tap = 32'h0001_2000;
      18:      tap = 32'h0002_0400;
      19:      tap = 32'h0004_0023;
      20:      tap = 32'h0009_0000;
      21:      tap = 32'h0014_0000;
      22:      tap = 32'h0030_0000;
      23:      tap = 32'h0042_0000;
      24:      tap = 32'h00E1_0000;
      25:      tap = 32'h0120_0000;
      26:      tap = 32'h0200_0023;
      27:      tap = 32'h0400_0013;
      28:      tap = 32'h0900_0000;
      29:      tap = 32'h1400_0000;
      30:      tap = 32'h2000_0029;
      31:      tap = 32'h4800_0000;
      default: tap = 32'h8020_0003;
    endcase
  endfunction

  // MISR feedback reuses the maximal-length table
  function automatic logic [31:0] sig_poly(input int n);
    sig_poly = tap(n);
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register with clear and enable.
// Folds an arbitrary-width response onto the signature width.
module bist_misr
  import gate_bist_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int N_OUT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [N_OUT-1:0] resp_i,
  output logic [SIG_W-1:0] sig_o
);

  localparam int NS = (N_OUT + SIG_W - 1) / SIG_W;
  localparam int XW = NS * SIG_W;
  localparam logic [SIG_W-1:0] POLY = SIG_W'(sig_poly(SIG_W));

  logic [SIG_W-1:0] misr_q;
  logic [SIG_W-1:0] misr_d;
  logic [XW-1:0]    resp_x;
  logic [SIG_W-1:0] fold_w [NS+1];

  assign resp_x    = XW'(resp_i);
  assign fold_w[0] = '0;

  for (genvar s = 0; s < NS; s++) begin : g_fold
    assign fold_w[s+1] = fold_w[s] ^ resp_x[s*SIG_W +: SIG_W];
  end

  // Next signature: clear wins, else shift-with-feedback plus folded response
  always_comb begin
    misr_d = misr_q;
    if (clr_i) begin
      misr_d = '0;
    end else if (en_i) begin
      misr_d = {misr_q[SIG_W-2:0], ^(misr_q & POLY)} ^ fold_w[NS];
    end
  end

  // Signature register
  always_ff @(posedge clk) begin
    if (!rst_n) misr_q <= '0;
    else        misr_q <= misr_d;
  end

  assign sig_o = misr_q;

endmodule

// File: rtl/gate_model_bist.sv
// LFSR-driven self-test wrapper for combinational gate models.
// Sequences LOAD/RUN/DRAIN/DONE and grades the MISR signature.
module gate_model_bist
  import gate_bist_pkg::*;
#(
  parameter int N_IN     = 18,
  parameter int N_OUT    = 10,
  parameter int SIG_W    = 16,
  parameter int N_PAT    = 1024,
  parameter int RESP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [N_IN-1:0]  seed_i,
  input  logic [SIG_W-1:0] expect_i,
  output logic [N_IN-1:0]  pat_o,
  input  logic [N_OUT-1:0] resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [SIG_W-1:0] sig_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int LW = (RESP_LAT > 0) ? RESP_LAT : 1;
  localparam logic [N_IN-1:0]  TAP_M  = N_IN'(tap(N_IN));
  localparam logic [CNT_W-1:0] NPAT_C = CNT_W'(N_PAT);
  localparam logic [1:0]       DLAST  = 2'(RESP_LAT - 1);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    vp_q, vp_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             run;
  logic             cap;
  logic             clr;

  assign run = (state_q == RUN);
  assign clr = (state_q == LOAD);
  assign cap = (RESP_LAT == 0) ? run : vp_q[LW-1];

  // Sequencer, pattern source, counters and valid pipe
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    pass_d  = pass_q;
    vp_d    = LW'({vp_q, run});
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        lfsr_d  = (seed_i == '0) ? N_IN'(1) : seed_i;
        cnt_d   = '0;
        dcnt_d  = '0;
        vp_d    = '0;
        pass_d  = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        lfsr_d = {lfsr_q[N_IN-2:0], ^(lfsr_q & TAP_M)};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_d == NPAT_C) begin
          state_d = (RESP_LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == DLAST) state_d = DONE;
      end
      DONE: begin
        pass_d  = (sig_o == expect_i);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      vp_q    <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      vp_q    <= vp_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  bist_misr #(
    .SIG_W (SIG_W),
    .N_OUT (N_OUT)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .en_i   (cap),
    .resp_i (resp_i),
    .sig_o  (sig_o)
  );

  assign pat_o  = lfsr_q;
  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;

endmodule
